fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
- Controller for the 4-tap 6-bit FIR tile.
- Owns the tile's pin-level protocol:
  - tile reset pulse
  - mode step, where x bit0 selects LSB readout; always driven 0 here
  - four coefficient-load steps
  - one advance step per sample
- Host side: register-write port for coefficients plus valid/ready sample-in and result-out streams.
- The tile is advanced only by single-cycle fir_step strobes, so the sequencer fully dictates tile timing.

Parameters:
N_TAPS, 4, number of taps; load phase issues exactly N_TAPS steps
BW_IN, 6, sample/coefficient width (signed)
BW_OUT, 8, tile output width (signed)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
coef_wr  input  1  write strobe for coefficient shadow bank
coef_idx  input  2  tap index 0..3 (tap k multiplies x delayed by k)
coef_data  input  BW_IN  signed coefficient value
start  input  1  pulse: (re)program tile, then enter RUN
stop  input  1  pulse: return to IDLE after any pending capture
busy  output  1  high in RST/MODE/LOAD states
s_valid  input  1  sample valid
s_ready  output  1  sample accepted when s_valid and s_ready
s_data  input  BW_IN  signed sample
m_valid  output  1  result valid
m_ready  input  1  result consumed when m_valid and m_ready
m_data  output  BW_OUT  signed result (tile y)
fir_rst  output  1  tile synchronous reset, qualified by fir_step
fir_step  output  1  one-cycle tile advance strobe
fir_x  output  BW_IN  tile x input, valid when fir_step=1
fir_y  input  BW_OUT  tile output, stable from the cycle after a RUN step

Behaviour:
- Async reset values:
  - state=IDLE
  - all outputs 0: fir_rst, fir_step, fir_x, s_ready, m_valid, m_data, busy
  - shadow coefficients 0
  - cap_pending=0, start_pend=0
- States:
  - IDLE:
    - s_ready=0.
    - start -> RST.
  - RST, 1 cycle:
    - fir_step=1, fir_rst=1, fir_x=0 -> MODE.
  - MODE, 1 cycle:
    - fir_step=1, fir_x=0 (LSB readout disabled) -> LOAD with load_cnt=N_TAPS-1.
  - LOAD, N_TAPS cycles:
    - fir_step=1, fir_x=shadow[load_cnt], in order tap3, tap2, tap1, tap0.
    - After load_cnt=0 -> RUN.
  - RUN:
    - s_ready = !m_valid && !cap_pending && !start_pend && !stop_pend.
    - Accept in cycle N: fir_step=1, fir_x=s_data, cap_pending<=1.
    - Cycle N+1: m_data<=fir_y, m_valid<=1, cap_pending<=0.
    - m_valid is high from cycle N+2 until the m_ready handshake.
    - Max throughput: 1 sample per 3 cycles with m_ready tied high.
- Latency: sample accept to m_valid rising is 2 cycles.
- start in RUN:
  - Latched into start_pend.
  - Honoured (-> RST) once cap_pending=0 and m_valid=0.
  - A result already in m_data is delivered first.
- start in RST/MODE/LOAD: ignored.
- stop:
  - Latched into stop_pend.
  - -> IDLE once cap_pending=0 and m_valid=0.
  - In RST/MODE/LOAD it takes effect after LOAD completes.
  - stop takes priority over start_pend if both are pending.
- Coefficient writes:
  - coef_wr updates the shadow register immediately in any state.
  - It takes effect in the tile only at the next start.
  - A write to the index currently being loaded in LOAD has no effect on the value stepped in that cycle; the new value applies at the next load.
- fir_rst is asserted only together with fir_step; fir_step is never high in IDLE.
- An async reset mid-sequence returns to IDLE; the tile is re-initialised only via start.

Optional Feature:
- FIR_SEQ_PERF_EN defined:
  - Adds outputs perf_samples[15:0] (accepted samples) and perf_stalls[15:0] (cycles in RUN with s_valid=1, s_ready=0).
  - Both are saturating, cleared by reset_n and by entering RST.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fir_seq_pkg holds:
  - state enum {IDLE, RST, MODE, LOAD, RUN}
  - N_TAPS, BW_IN, BW_OUT defaults
  - coef_t (signed BW_IN)
- Sub-module fir_seq_coef_bank: N_TAPS shadow registers with write port and combinational read by load_cnt.

Test Plan:
- Program taps (31, 16, -32, 8), start -> steps per state: RST 1, MODE 1, LOAD 4 with fir_x 8, -32, 16, 31; busy high for exactly 6 cycles.
- Behavioural tile model, impulse 31 then 0, 0, 0 -> m_data 15, 7, -16 (8'hF0), 3.
- m_ready held low 10 cycles after first result -> m_valid and m_data stable, s_ready=0 throughout, no extra fir_step.
- start asserted during capture -> result delivered first, then RST sequence; new taps apply to the next sample.
- reset_n low during LOAD step 2 -> all outputs 0 immediately, state IDLE, no fir_step until the next start.
- stop with s_valid held high -> pending result drains, IDLE reached, s_ready stays 0.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FIR tap sequencer.
//   state_e : sequencer states (IDLE, RST, MODE, LOAD, RUN)
//   coef_t  : signed coefficient/sample type at the default width
//   *_DEF   : default tap count and data widths of the 4-tap 6-bit tile
package fir_seq_pkg;

  localparam int unsigned N_TAPS_DEF = 4;
  localparam int unsigned BW_IN_DEF  = 6;
  localparam int unsigned BW_OUT_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    MODE,
    LOAD,
    RUN
  } state_e;

  typedef logic signed [BW_IN_DEF-1:0] coef_t;

endpackage

// File: rtl/fir_seq_coef_bank.sv
// Shadow coefficient bank for the FIR tap sequencer.
// Host writes land here immediately; the sequencer reads one entry per LOAD
// cycle, so a write only reaches the tile at the next programming sequence.
//   clk, reset_n : clock, asynchronous active-low reset (clears all taps)
//   wr_en_i      : write strobe
//   wr_idx_i     : tap index to write
//   wr_data_i    : signed coefficient value
//   rd_idx_i     : tap index to read (combinational)
//   rd_data_o    : coefficient at rd_idx_i
module fir_seq_coef_bank
  import fir_seq_pkg::*;
#(
  parameter int unsigned N_TAPS = N_TAPS_DEF,
  parameter int unsigned BW_IN  = BW_IN_DEF,
  localparam int unsigned IDX_W = $clog2(N_TAPS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic signed [BW_IN-1:0] wr_data_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic signed [BW_IN-1:0] rd_data_o
);

  logic signed [BW_IN-1:0] coef_q [N_TAPS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      coef_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read returns the pre-write value during a same-cycle write, so a write to
  // the tap being loaded never alters that cycle's step.
  assign rd_data_o = coef_q[rd_idx_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Controller for the 4-tap 6-bit FIR tile.
// Drives the tile pin protocol (reset step, mode step, N_TAPS coefficient
// steps tap N-1 first, then one step per accepted sample) and bridges it to a
// host coefficient write port and valid/ready sample/result streams.
//   clk, reset_n           : clock, asynchronous active-low reset
//   coef_wr/idx/data       : shadow coefficient write port
//   start, stop            : program-then-run / return-to-idle pulses
//   busy                   : high while programming (RST/MODE/LOAD)
//   s_valid/s_ready/s_data : sample input stream
//   m_valid/m_ready/m_data : result output stream
//   fir_rst/fir_step/fir_x : tile control and data, qualified by fir_step
//   fir_y                  : tile output
// Optional: define FIR_SEQ_PERF_EN to add saturating perf_samples (accepted
// samples) and perf_stalls (RUN cycles with s_valid && !s_ready) outputs.
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned N_TAPS = N_TAPS_DEF,
  parameter int unsigned BW_IN  = BW_IN_DEF,
  parameter int unsigned BW_OUT = BW_OUT_DEF,
  localparam int unsigned IDX_W = $clog2(N_TAPS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     coef_wr,
  input  logic [IDX_W-1:0]         coef_idx,
  input  logic signed [BW_IN-1:0]  coef_data,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [BW_IN-1:0]  s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [BW_OUT-1:0] m_data,
  output logic                     fir_rst,
  output logic                     fir_step,
  output logic signed [BW_IN-1:0]  fir_x,
  input  logic signed [BW_OUT-1:0] fir_y
`ifdef FIR_SEQ_PERF_EN
  ,output logic [15:0]             perf_samples
  ,output logic [15:0]             perf_stalls
`endif
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        load_cnt_q, load_cnt_d;
  logic                    cap_q, cap_d;
  logic                    start_pend_q, start_pend_d;
  logic                    stop_pend_q, stop_pend_d;
  logic                    m_valid_q, m_valid_d;
  logic signed [BW_OUT-1:0] m_data_q, m_data_d;
  logic signed [BW_IN-1:0] coef_rd;
  logic                    accept;

  fir_seq_coef_bank #(
    .N_TAPS (N_TAPS),
    .BW_IN  (BW_IN)
  ) u_coef_bank (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (coef_wr),
    .wr_idx_i  (coef_idx),
    .wr_data_i (coef_data),
    .rd_idx_i  (load_cnt_q),
    .rd_data_o (coef_rd)
  );

  // One sample in flight at a time: a new sample is refused while its result
  // is being captured or waiting for the host, or while a start/stop is queued.
  assign s_ready = (state_q == RUN) && !m_valid_q && !cap_q
                   && !start_pend_q && !stop_pend_q;
  assign accept  = s_valid && s_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    cap_d        = cap_q;
    start_pend_d = start_pend_q;
    stop_pend_d  = stop_pend_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    fir_step     = 1'b0;
    fir_rst      = 1'b0;
    fir_x        = '0;
    busy         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = RST;
      end
      RST: begin
        busy     = 1'b1;
        fir_step = 1'b1;
        fir_rst  = 1'b1;
        if (stop) stop_pend_d = 1'b1;
        state_d  = MODE;
      end
      MODE: begin
        busy       = 1'b1;
        fir_step   = 1'b1;
        if (stop) stop_pend_d = 1'b1;
        load_cnt_d = IDX_W'(N_TAPS - 1);
        state_d    = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        fir_step = 1'b1;
        fir_x    = coef_rd;
        if (stop) stop_pend_d = 1'b1;
        if (load_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          load_cnt_d = load_cnt_q - IDX_W'(1);
        end
      end
      RUN: begin
        if (start) start_pend_d = 1'b1;
        if (stop)  stop_pend_d  = 1'b1;
        if (accept) begin
          fir_step = 1'b1;
          fir_x    = s_data;
          cap_d    = 1'b1;
        end
        // Tile output settles the cycle after its step; capture it then.
        if (cap_q) begin
          m_data_d  = fir_y;
          m_valid_d = 1'b1;
          cap_d     = 1'b0;
        end
        if (m_valid_q && m_ready) m_valid_d = 1'b0;
        // Leave only once no result is in flight; stop wins over start.
        if (!cap_q && !m_valid_q) begin
          if (stop_pend_q) begin
            state_d      = IDLE;
            stop_pend_d  = 1'b0;
            start_pend_d = 1'b0;
          end else if (start_pend_q) begin
            state_d      = RST;
            start_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      cap_q        <= 1'b0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      cap_q        <= cap_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
    end
  end

`ifdef FIR_SEQ_PERF_EN
  logic [15:0] perf_samples_q;
  logic [15:0] perf_stalls_q;
  logic        stall;

  assign stall = (state_q == RUN) && s_valid && !s_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_samples_q <= '0;
      perf_stalls_q  <= '0;
    end else if (state_d == RST && state_q != RST) begin
      perf_samples_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (accept && perf_samples_q != '1) perf_samples_q <= perf_samples_q + 16'd1;
      if (stall && perf_stalls_q != '1)   perf_stalls_q  <= perf_stalls_q + 16'd1;
    end
  end

  assign perf_samples = perf_samples_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer with a behavioural FIR tile model
// attached to the tile pins and a host-side golden FIR feeding a scoreboard.
module tb_fir_tap_sequencer;
  import fir_seq_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              coef_wr;
  logic [1:0]        coef_idx;
  logic signed [5:0] coef_data;
  logic              start, stop, busy;
  logic              s_valid, s_ready;
  logic signed [5:0] s_data;
  logic              m_valid, m_ready;
  logic signed [7:0] m_data;
  logic              fir_rst, fir_step;
  logic signed [5:0] fir_x;
  logic signed [7:0] fir_y;
`ifdef FIR_SEQ_PERF_EN
  logic [15:0]       perf_samples, perf_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .coef_wr   (coef_wr),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .fir_rst   (fir_rst),
    .fir_step  (fir_step),
    .fir_x     (fir_x),
    .fir_y     (fir_y)
`ifdef FIR_SEQ_PERF_EN
    ,.perf_samples (perf_samples)
    ,.perf_stalls  (perf_stalls)
`endif
  );

  // Behavioural tile: reset step, mode step, taps loaded tap3 first, then one
  // output per step: y = (sum c_k * x[n-k]) >>> 6, registered.
  coef_t t_c [4];
  int    t_h [3];
  int    t_phase = 0;
  int    t_s;
  logic signed [7:0] t_y = '0;
  assign fir_y = t_y;

  always @(posedge clk) begin
    if (fir_step) begin
      if (fir_rst) begin
        t_phase <= 1;
        t_h[0] <= 0; t_h[1] <= 0; t_h[2] <= 0;
        t_y <= '0;
      end else if (t_phase == 1) begin
        t_phase <= 2;
      end else if (t_phase >= 2 && t_phase <= 5) begin
        t_c[5 - t_phase] <= fir_x;
        t_phase <= t_phase + 1;
      end else if (t_phase == 6) begin
        t_s = int'(t_c[0]) * int'(fir_x) + int'(t_c[1]) * t_h[0]
            + int'(t_c[2]) * t_h[1] + int'(t_c[3]) * t_h[2];
        t_y <= 8'(t_s >>> 6);
        t_h[2] <= t_h[1]; t_h[1] <= t_h[0]; t_h[0] <= int'(fir_x);
      end
    end
  end

  // Host-side golden model and scoreboard
  int sh [4];
  int gold_taps [4];
  int gold_hist [3];
  logic signed [7:0] sb_q [$];

  function automatic logic signed [7:0] gold_push(input int x);
    int s;
    s = gold_taps[0] * x;
    for (int k = 1; k < 4; k++) s += gold_taps[k] * gold_hist[k-1];
    gold_hist[2] = gold_hist[1];
    gold_hist[1] = gold_hist[0];
    gold_hist[0] = x;
    return 8'(s >>> 6);
  endfunction

  task automatic write_coef(input int idx, input int val);
    coef_wr = 1'b1; coef_idx = 2'(idx); coef_data = 6'(val);
    sh[idx] = val;
    @(negedge clk);
    coef_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    for (int k = 0; k < 4; k++) gold_taps[k] = sh[k];
    for (int k = 0; k < 3; k++) gold_hist[k] = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic signed [5:0] x, output bit ok);
    s_valid = 1'b1; s_data = x; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic collect(output logic signed [7:0] d, output int waited, output bit ok);
    ok = 1'b0; waited = 0; d = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_valid && m_ready) begin
        d = m_data; ok = 1'b1;
      end else begin
        waited++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    reset_n = 1'b0;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    obs = {fir_rst, fir_step, fir_x, s_ready, m_valid, m_data, busy, 2'b00};
    n_checks++;
    if (obs !== 26'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({fir_step, s_ready, busy} !== 3'b000) begin
        n_fail++; $display("FAIL idle_quiet: step/ready/busy=%b expected 000", {fir_step, s_ready, busy});
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_program();
    logic [9:0] tab [8];
    logic [9:0] obs;
    int bc = 0;
    tab[0] = {3'b111, 6'h00, 1'b0};
    tab[1] = {3'b110, 6'h00, 1'b0};
    tab[2] = {3'b110, 6'h08, 1'b0};
    tab[3] = {3'b110, 6'h20, 1'b0};
    tab[4] = {3'b110, 6'h10, 1'b0};
    tab[5] = {3'b110, 6'h1F, 1'b0};
    tab[6] = {3'b000, 6'h00, 1'b1};
    tab[7] = {3'b000, 6'h00, 1'b1};
    write_coef(0, 31); write_coef(1, 16); write_coef(2, -32); write_coef(3, 8);
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      obs = {busy, fir_step, fir_rst, fir_x, s_ready};
      if (busy) bc++;
      n_checks++;
      if (obs !== tab[c]) begin
        n_fail++; $display("FAIL program_seq[%0d]: got %b expected %b", c, obs, tab[c]);
      end
      // Overwrite tap3 while it is being stepped, then restore it.
      if (c == 2) begin coef_wr = 1'b1; coef_idx = 2'd3; coef_data = 6'h3F; end
      if (c == 3) coef_data = 6'sd8;
      if (c == 4) coef_wr = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (bc != 6) begin
      n_fail++; $display("FAIL busy_cycles: got %0d expected 6", bc);
    end
  endtask

  task automatic test_impulse();
    logic signed [5:0] xs [4];
    logic signed [7:0] got, exp;
    int w; bit ok;
    xs[0] = 6'sd31; xs[1] = 6'sd0; xs[2] = 6'sd0; xs[3] = 6'sd0;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(gold_push(int'(xs[i])));
      send(xs[i], ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL impulse_accept[%0d]: s_ready never rose", i); end
      collect(got, w, ok);
      exp = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++; $display("FAIL impulse_result[%0d]: got %0d expected %0d (ok=%0d)", i, got, exp, ok);
      end
      if (i == 0) begin
        n_checks++;
        if (w != 1) begin n_fail++; $display("FAIL latency: waited %0d expected 1", w); end
      end
    end
  endtask

  task automatic test_stall();
    logic signed [7:0] got, exp;
    int w; bit ok;
    m_ready = 1'b0;
    sb_q.push_back(gold_push(-7));
    send(-6'sd7, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_accept: s_ready never rose"); end
    s_valid = 1'b1; s_data = 6'sd9;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({m_valid, s_ready, fir_step} !== 3'b100 || m_data !== sb_q[0]) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid/ready/step=%b data=%0d expected 100 data=%0d",
                 i, {m_valid, s_ready, fir_step}, m_data, sb_q[0]);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    collect(got, w, ok);
    exp = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++; $display("FAIL stall_result: got %0d expected %0d (ok=%0d)", got, exp, ok);
    end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drop: m_valid=%b expected 0", m_valid); end
  endtask

  task automatic test_start_during_capture();
    logic signed [7:0] got, exp;
    int w, bc; bit ok, seen;
    write_coef(0, -20); write_coef(1, 10); write_coef(2, 5); write_coef(3, -3);
    sb_q.push_back(gold_push(12));
    send(6'sd12, ok);
    pulse_start();
    n_checks++;
    if ({m_valid, busy} !== 2'b10) begin
      n_fail++; $display("FAIL start_result_first: valid/busy=%b expected 10", {m_valid, busy});
    end
    collect(got, w, ok);
    exp = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++; $display("FAIL start_old_taps: got %0d expected %0d (ok=%0d)", got, exp, ok);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (busy) seen = 1'b1; else @(negedge clk);
    end
    bc = 0;
    for (int i = 0; i < 20 && busy; i++) begin bc++; @(negedge clk); end
    n_checks++;
    if (!seen || bc != 6) begin
      n_fail++; $display("FAIL restart_busy: busy cycles %0d expected 6 (seen=%0d)", bc, seen);
    end
    sb_q.push_back(gold_push(20));
    send(6'sd20, ok);
    collect(got, w, ok);
    exp = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++; $display("FAIL start_new_taps: got %0d expected %0d (ok=%0d)", got, exp, ok);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [25:0] obs;
    bit seen;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (busy) seen = 1'b1; else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!seen || {busy, fir_step, fir_rst} !== 3'b110) begin
      n_fail++; $display("FAIL mid_load_reach: busy/step/rst=%b expected 110", {busy, fir_step, fir_rst});
    end
    reset_n = 1'b0;
    #1;
    obs = {fir_rst, fir_step, fir_x, s_ready, m_valid, m_data, busy, 2'b00};
    n_checks++;
    if (obs !== 26'd0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", obs); end
    for (int k = 0; k < 4; k++) sh[k] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({fir_step, busy} !== 2'b00) begin
        n_fail++; $display("FAIL post_reset_idle[%0d]: step/busy=%b expected 00", i, {fir_step, busy});
      end
    end
    write_coef(0, 31); write_coef(1, 16); write_coef(2, -32); write_coef(3, 8);
    pulse_start();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
  endtask

  task automatic test_stop();
    logic signed [7:0] got, exp;
    int w; bit ok;
    s_valid = 1'b1; s_data = -6'sd25; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stop_accept: s_ready never rose"); end
    sb_q.push_back(gold_push(-25));
    s_data = 6'sd17;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    collect(got, w, ok);
    exp = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin
      n_fail++; $display("FAIL stop_drain: got %0d expected %0d (ok=%0d)", got, exp, ok);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({s_ready, fir_step, busy, m_valid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL stop_idle[%0d]: ready/step/busy/valid=%b expected 0000", i, {s_ready, fir_step, busy, m_valid});
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; coef_wr = 1'b0; coef_idx = '0; coef_data = '0;
    start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin sh[k] = 0; gold_taps[k] = 0; end
    for (int k = 0; k < 3; k++) gold_hist[k] = 0;
    @(negedge clk);
    test_reset();
    test_program();
    test_impulse();
    test_stall();
    test_start_during_capture();
    test_reset_mid_load();
    test_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
